exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage between ID and MEM. Registers the decoded ID payload and runs the 12-op ALU.
//  Also runs a single-cycle 32x32 multiplier and a 32-iteration radix-2 divider behind an FSM.
//  Issues the data-SRAM request and drives the EXE forwarding/hazard bus back to ID.
// PARAMETERS
//  DW        32  datapath width; only 32 is supported
//  ALU_OP_W  12  alu_op one-hot width
//  MD_OP_W    7  mul_div_op {mul_w,mulh_w,mulh_wu,div_w,mod_w,div_wu,mod_wu}, bit6..bit0
// PORTS
//  clk              in   1   clock
//  resetn           in   1   synchronous active-low reset
//  id_to_exe_valid  in   1   ID payload valid
//  exe_allowin      out  1   EXE can accept this cycle
//  id_pc,id_src1,id_src2,id_st_data  in 32 each  pc, ALU operands, store data
//  id_gr_we,id_rfrom_mem,id_mem_en  in 1 each   reg write, load, store
//  id_dest          in   5   destination register
//  id_mem_we        in   4   byte write enables
//  id_load_op       in   4   load type
//  id_alu_op        in   12  one-hot ALU op
//  id_md_op         in   7   one-hot mul/div op; all zero = ALU instruction
//  mem_allowin      in   1   MEM can accept
//  exe_to_mem_valid out  1   EXE result valid to MEM
//  exe_pc,exe_result out 32  pc and final result (ALU/mul/div)
//  exe_gr_we,exe_rfrom_mem out 1; exe_dest out 5; exe_load_op out 4  passed through
//  data_sram_en     out  1   SRAM request
//  data_sram_we     out  4   byte write enables
//  data_sram_addr,data_sram_wdata out 32  address and store data
//  exe_fw_dest      out  5   dest when exe_valid&gr_we, else 0
//  exe_fw_block     out  1   result not forwardable this cycle (ID must stall)
//  exe_fw_result    out  32  exe_result
// BEHAVIOUR
//  - Handshake: allowin = !exe_valid | (ready_go & mem_allowin); to_mem_valid = exe_valid & ready_go.
//  - Valid capture: on allowin, exe_valid <= id_to_exe_valid.
//  - Payload capture: payload regs load when id_to_exe_valid & allowin; otherwise they hold.
//  - ready_go = !is_div | div_state==DONE. is_div = |id_md_op[3:0]. Mul and ALU finish in 0 extra cycles.
//  - ALU ops: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui(=src2).
//  - Shift amount is src2[4:0].
//  - mul_w gives product[31:0], signed. mulh_w gives product[63:32], signed. mulh_wu gives product[63:32], unsigned.
//  - Divider FSM, states IDLE/BUSY/DONE:
//      IDLE->BUSY when exe_valid&is_div. Latch |dividend| and |divisor| (unsigned ops: raw); cnt<=0.
//      BUSY: one restoring step per cycle; after 32 steps (cnt==31) go to DONE.
//      DONE: hold q/r; DONE->IDLE when mem_allowin (instruction leaves EXE).
//      Timing: instruction enters EXE in cycle N; ready_go first high in N+33.
//  - Signed fix-up: quotient sign = sa^sb; remainder sign = sa.
//  - 0x80000000 / -1 gives q=0x80000000, r=0.
//  - Divide by zero gives q=0xFFFFFFFF (signed: sign fix applied), r=dividend. No trap.
//  - data_sram_en = exe_valid & (mem_en|rfrom_mem).
//  - data_sram_we = mem_we & {4{exe_valid}}; addr = ALU sum; wdata = st_data.
//  - exe_fw_block = exe_valid & gr_we & (rfrom_mem | (is_div & div_state!=DONE)).
//  - Back-pressure (mem_allowin=0 while to_mem_valid): all outputs hold stable; divider stays in DONE.
//  - Reset values: exe_valid=0, div_state=IDLE, cnt=0, payload regs=0.
//    Hence to_mem_valid=0, data_sram_en=0, we=0, fw_dest=0, fw_block=0.
//  - Reset asserted mid-division aborts it: next cycle state=IDLE, exe_valid=0.
// CONFIGURATION
//  EXE_DIV_EARLY_OUT_EN defined:
//    In IDLE, if |dividend| < |divisor| or divisor==0, skip BUSY and go straight to DONE.
//    Result is q=0, r=dividend; divide-by-zero gives q=0xFFFFFFFF. ready_go is high at N+1.
//  EXE_DIV_EARLY_OUT_EN undefined: every divide takes the full 32 iterations (N+33).
// TESTING
//  1. add.w, src1=5, src2=-3, mem_allowin=1 -> exe_result=2; to_mem_valid the cycle after entry.
//  2. div_w 7/-2 -> q=0xFFFFFFFD; mod_w 7/-2 -> r=1.
//     ready_go at N+33; fw_block=1 during N..N+32; allowin=0 throughout.
//  3. div_wu 5/0 -> 0xFFFFFFFF; mod_wu 5/0 -> 5.
//     div_w 0x80000000/0xFFFFFFFF -> 0x80000000.
//  4. mulh_w 0x80000000*2 -> 0xFFFFFFFF; mulh_wu same operands -> 0x00000001.
//  5. st.w with mem_allowin=0 for 3 cycles:
//     data_sram_we=4'hF and addr/wdata stable for all 3; allowin=0; one transfer when mem_allowin=1.
//  6. resetn=0 at BUSY cnt=10 -> next cycle exe_valid=0, state IDLE.
//     A following div gives the correct result at full latency.

Source files
------------

// File: rtl/exe_stage.sv
`default_nettype none
// exe_stage: EXE pipeline stage with 12-op ALU, 1-cycle 32x32 multiplier and radix-2 restoring divider.
// Optional EXE_DIV_EARLY_OUT_EN lets trivial divides (|a|<|b| or b==0) skip the iterations. Rev 1.0
module exe_stage #(
  parameter int DW       = 32,
  parameter int ALU_OP_W = 12,
  parameter int MD_OP_W  = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                id_to_exe_valid,
  output logic                exe_allowin,
  input  logic [DW-1:0]       id_pc,
  input  logic [DW-1:0]       id_src1,
  input  logic [DW-1:0]       id_src2,
  input  logic [DW-1:0]       id_st_data,
  input  logic                id_gr_we,
  input  logic                id_rfrom_mem,
  input  logic                id_mem_en,
  input  logic [4:0]          id_dest,
  input  logic [3:0]          id_mem_we,
  input  logic [3:0]          id_load_op,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [MD_OP_W-1:0]  id_md_op,
  input  logic                mem_allowin,
  output logic                exe_to_mem_valid,
  output logic [DW-1:0]       exe_pc,
  output logic [DW-1:0]       exe_result,
  output logic                exe_gr_we,
  output logic                exe_rfrom_mem,
  output logic [4:0]          exe_dest,
  output logic [3:0]          exe_load_op,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [DW-1:0]       data_sram_addr,
  output logic [DW-1:0]       data_sram_wdata,
  output logic [4:0]          exe_fw_dest,
  output logic                exe_fw_block,
  output logic [DW-1:0]       exe_fw_result
);

  localparam int             CW       = $clog2(DW);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  logic                exe_valid_q, exe_valid_d;
  logic [DW-1:0]       pc_q, pc_d, src1_q, src1_d, src2_q, src2_d, st_data_q, st_data_d;
  logic                gr_we_q, gr_we_d, rfrom_mem_q, rfrom_mem_d, mem_en_q, mem_en_d;
  logic [4:0]          dest_q, dest_d;
  logic [3:0]          mem_we_q, mem_we_d, load_op_q, load_op_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [MD_OP_W-1:0]  md_op_q, md_op_d;

  div_state_e          div_state_q, div_state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       rem_q, rem_d, quo_q, quo_d, dsor_q, dsor_d;
  logic                sa_q, sa_d, sb_q, sb_d;

  logic                ready_go, load_payload, is_div, div_signed, mul_signed;

  assign is_div       = |md_op_q[3:0];
  assign div_signed   = md_op_q[3] | md_op_q[2];
  assign mul_signed   = md_op_q[6] | md_op_q[5];
  assign ready_go     = !is_div || (div_state_q == DIV_DONE);
  assign exe_allowin  = !exe_valid_q || (ready_go && mem_allowin);
  assign load_payload = id_to_exe_valid && exe_allowin;

  always_comb begin
    exe_valid_d = exe_allowin ? id_to_exe_valid : exe_valid_q;
    pc_d        = load_payload ? id_pc        : pc_q;
    src1_d      = load_payload ? id_src1      : src1_q;
    src2_d      = load_payload ? id_src2      : src2_q;
    st_data_d   = load_payload ? id_st_data   : st_data_q;
    gr_we_d     = load_payload ? id_gr_we     : gr_we_q;
    rfrom_mem_d = load_payload ? id_rfrom_mem : rfrom_mem_q;
    mem_en_d    = load_payload ? id_mem_en    : mem_en_q;
    dest_d      = load_payload ? id_dest      : dest_q;
    mem_we_d    = load_payload ? id_mem_we    : mem_we_q;
    load_op_d   = load_payload ? id_load_op   : load_op_q;
    alu_op_d    = load_payload ? id_alu_op    : alu_op_q;
    md_op_d     = load_payload ? id_md_op     : md_op_q;
  end

  // ALU: one-hot select, AND-OR muxed
  logic [DW-1:0] alu_sum, alu_res;
  logic [4:0]    shamt;

  assign alu_sum = src1_q + src2_q;
  assign shamt   = src2_q[4:0];
  assign alu_res =
      ({DW{alu_op_q[0]}}  & alu_sum)
    | ({DW{alu_op_q[1]}}  & (src1_q - src2_q))
    | ({DW{alu_op_q[2]}}  & {{(DW-1){1'b0}}, ($signed(src1_q) < $signed(src2_q))})
    | ({DW{alu_op_q[3]}}  & {{(DW-1){1'b0}}, (src1_q < src2_q)})
    | ({DW{alu_op_q[4]}}  & (src1_q & src2_q))
    | ({DW{alu_op_q[5]}}  & ~(src1_q | src2_q))
    | ({DW{alu_op_q[6]}}  & (src1_q | src2_q))
    | ({DW{alu_op_q[7]}}  & (src1_q ^ src2_q))
    | ({DW{alu_op_q[8]}}  & (src1_q << shamt))
    | ({DW{alu_op_q[9]}}  & (src1_q >> shamt))
    | ({DW{alu_op_q[10]}} & $unsigned($signed(src1_q) >>> shamt))
    | ({DW{alu_op_q[11]}} & src2_q);

  logic signed [2*DW-1:0] mul_a, mul_b;
  logic [2*DW-1:0]        product;

  assign mul_a   = {{DW{mul_signed & src1_q[DW-1]}}, src1_q};
  assign mul_b   = {{DW{mul_signed & src2_q[DW-1]}}, src2_q};
  assign product = mul_a * mul_b;

  // Divider operates on magnitudes; signs are reapplied on the way out
  logic [DW-1:0] abs_a, abs_b, step_sub, quo_fix, rem_fix;
  logic [DW:0]   rem_shift;
  logic          step_ge;

  assign abs_a     = (div_signed && src1_q[DW-1]) ? (~src1_q + 1'b1) : src1_q;
  assign abs_b     = (div_signed && src2_q[DW-1]) ? (~src2_q + 1'b1) : src2_q;
  assign rem_shift = {rem_q, quo_q[DW-1]};
  assign step_ge   = rem_shift >= {1'b0, dsor_q};
  assign step_sub  = rem_shift[DW-1:0] - dsor_q;
  assign quo_fix   = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix   = sa_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    div_state_d = div_state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsor_d      = dsor_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (exe_valid_q && is_div) begin
          sa_d        = div_signed & src1_q[DW-1];
          sb_d        = div_signed & src2_q[DW-1];
          dsor_d      = abs_b;
          quo_d       = abs_a;
          rem_d       = '0;
          cnt_d       = '0;
          div_state_d = DIV_BUSY;
`ifdef EXE_DIV_EARLY_OUT_EN
          if ((abs_b == '0) || (abs_a < abs_b)) begin
            quo_d       = (abs_b == '0) ? '1 : '0;
            rem_d       = abs_a;
            div_state_d = DIV_DONE;
          end
`endif
        end
      end
      DIV_BUSY: begin
        quo_d = {quo_q[DW-2:0], step_ge};
        rem_d = step_ge ? step_sub : rem_shift[DW-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) div_state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (mem_allowin) div_state_d = DIV_IDLE;
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      pc_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      st_data_q   <= '0;
      gr_we_q     <= 1'b0;
      rfrom_mem_q <= 1'b0;
      mem_en_q    <= 1'b0;
      dest_q      <= '0;
      mem_we_q    <= '0;
      load_op_q   <= '0;
      alu_op_q    <= '0;
      md_op_q     <= '0;
      div_state_q <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsor_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
    end else begin
      exe_valid_q <= exe_valid_d;
      pc_q        <= pc_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      st_data_q   <= st_data_d;
      gr_we_q     <= gr_we_d;
      rfrom_mem_q <= rfrom_mem_d;
      mem_en_q    <= mem_en_d;
      dest_q      <= dest_d;
      mem_we_q    <= mem_we_d;
      load_op_q   <= load_op_d;
      alu_op_q    <= alu_op_d;
      md_op_q     <= md_op_d;
      div_state_q <= div_state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsor_q      <= dsor_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
    end
  end

  always_comb begin
    exe_result = alu_res;
    if (md_op_q[6])                    exe_result = product[DW-1:0];
    else if (md_op_q[5] | md_op_q[4])  exe_result = product[2*DW-1:DW];
    else if (md_op_q[3] | md_op_q[1])  exe_result = quo_fix;
    else if (md_op_q[2] | md_op_q[0])  exe_result = rem_fix;
  end

  assign exe_to_mem_valid = exe_valid_q && ready_go;
  assign exe_pc           = pc_q;
  assign exe_gr_we        = gr_we_q;
  assign exe_rfrom_mem    = rfrom_mem_q;
  assign exe_dest         = dest_q;
  assign exe_load_op      = load_op_q;
  assign data_sram_en     = exe_valid_q && (mem_en_q || rfrom_mem_q);
  assign data_sram_we     = mem_we_q & {4{exe_valid_q}};
  assign data_sram_addr   = alu_sum;
  assign data_sram_wdata  = st_data_q;
  assign exe_fw_dest      = (exe_valid_q && gr_we_q) ? dest_q : 5'd0;
  assign exe_fw_block     = exe_valid_q && gr_we_q &&
                            (rfrom_mem_q || (is_div && (div_state_q != DIV_DONE)));
  assign exe_fw_result    = exe_result;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// tb_exe_stage: vector table, directed multi-cycle sequences and randomized ops checked against an arithmetic model.
module tb_exe_stage;

  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004, OP_SLTU = 12'h008,
                          OP_AND = 12'h010, OP_NOR = 12'h020, OP_OR  = 12'h040, OP_XOR  = 12'h080,
                          OP_SLL = 12'h100, OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI  = 12'h800;
  localparam logic [6:0]  MD_MUL_W = 7'h40, MD_MULH_W = 7'h20, MD_MULH_WU = 7'h10, MD_DIV_W = 7'h08,
                          MD_MOD_W = 7'h04, MD_DIV_WU = 7'h02, MD_MOD_WU  = 7'h01;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        id_to_exe_valid = 1'b0;
  logic        exe_allowin;
  logic [31:0] id_pc = '0, id_src1 = '0, id_src2 = '0, id_st_data = '0;
  logic        id_gr_we = 1'b0, id_rfrom_mem = 1'b0, id_mem_en = 1'b0;
  logic [4:0]  id_dest = '0;
  logic [3:0]  id_mem_we = '0, id_load_op = '0;
  logic [11:0] id_alu_op = '0;
  logic [6:0]  id_md_op = '0;
  logic        mem_allowin = 1'b1;
  logic        exe_to_mem_valid;
  logic [31:0] exe_pc, exe_result;
  logic        exe_gr_we, exe_rfrom_mem;
  logic [4:0]  exe_dest;
  logic [3:0]  exe_load_op;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [4:0]  exe_fw_dest;
  logic        exe_fw_block;
  logic [31:0] exe_fw_result;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .resetn(resetn), .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
    .id_pc(id_pc), .id_src1(id_src1), .id_src2(id_src2), .id_st_data(id_st_data),
    .id_gr_we(id_gr_we), .id_rfrom_mem(id_rfrom_mem), .id_mem_en(id_mem_en), .id_dest(id_dest),
    .id_mem_we(id_mem_we), .id_load_op(id_load_op), .id_alu_op(id_alu_op), .id_md_op(id_md_op),
    .mem_allowin(mem_allowin), .exe_to_mem_valid(exe_to_mem_valid), .exe_pc(exe_pc),
    .exe_result(exe_result), .exe_gr_we(exe_gr_we), .exe_rfrom_mem(exe_rfrom_mem),
    .exe_dest(exe_dest), .exe_load_op(exe_load_op), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .exe_fw_dest(exe_fw_dest), .exe_fw_block(exe_fw_block), .exe_fw_result(exe_fw_result)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions of each op
  function automatic logic [31:0] ref_res(input logic [11:0] alu, input logic [6:0] md,
                                          input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [4:0]      sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = b[4:0];
    case (md)
      MD_MUL_W:   begin p = sa * sb; return p[31:0]; end
      MD_MULH_W:  begin p = sa * sb; return p[63:32]; end
      MD_MULH_WU: begin p = ua * ub; return p[63:32]; end
      MD_DIV_W: begin
        if (b == 0) return a[31] ? 32'd1 : 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MD_MOD_W: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      MD_DIV_WU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_MOD_WU: return (b == 0) ? a : a % b;
      default: ;
    endcase
    case (alu)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $unsigned($signed(a) >>> sh);
      OP_LUI:  return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_payload(input logic [11:0] alu, input logic [6:0] md, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] st, input logic gr_we,
                             input logic rfrom, input logic men, input logic [3:0] we,
                             input logic [3:0] lop, input logic [4:0] dest);
    id_alu_op = alu; id_md_op = md; id_src1 = a; id_src2 = b; id_st_data = st;
    id_gr_we = gr_we; id_rfrom_mem = rfrom; id_mem_en = men; id_mem_we = we;
    id_load_op = lop; id_dest = dest; id_pc = 32'h1C00_0000 + 32'($urandom_range(0, 255) * 4);
  endtask

  // Issue one register-writing instruction from a negedge, wait for it and let it leave
  task automatic run_instr(input string name, input logic [11:0] alu, input logic [6:0] md,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input int stall);
    int         lat;
    int         exp_lat;
    logic       stall_ok;
    logic [4:0] dest;
    dest     = 5'($urandom_range(1, 31));
    exp_lat  = (|md[3:0]) ? 33 : 0;
    stall_ok = 1'b1;
    mem_allowin = 1'b1;
    set_payload(alu, md, a, b, 32'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, dest);
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1 id_to_exe_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!exe_to_mem_valid && lat < 60) begin
      if (!(exe_fw_block === 1'b1 && exe_allowin === 1'b0)) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " result"}, exe_result, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " fw_dest"}, {27'd0, exe_fw_dest}, {27'd0, dest});
    check({name, " fw_block at ready"}, {31'd0, exe_fw_block}, 32'd0);
    if (exp_lat > 0) check({name, " stall flags"}, {31'd0, stall_ok}, 32'd1);
    if (stall > 0) begin
      mem_allowin = 1'b0;
      repeat (stall) @(negedge clk);
      check({name, " held result"}, exe_result, exp);
      check({name, " held valid"}, {31'd0, exe_to_mem_valid}, 32'd1);
      mem_allowin = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [11:0] alu;
    logic [6:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mkv(input string n, input logic [11:0] alu, input logic [6:0] md,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.name = n; v.alu = alu; v.md = md; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [11:0] alu_tab[12];
    logic [6:0]  md_tab[7];

    tbl.push_back(mkv("add",      OP_ADD,  7'h0, 32'd5,        32'hFFFF_FFFD, 32'd2));
    tbl.push_back(mkv("sub",      OP_SUB,  7'h0, 32'd5,        32'd7,         32'hFFFF_FFFE));
    tbl.push_back(mkv("slt",      OP_SLT,  7'h0, 32'hFFFF_FFFF, 32'd1,        32'd1));
    tbl.push_back(mkv("sltu",     OP_SLTU, 7'h0, 32'hFFFF_FFFF, 32'd1,        32'd0));
    tbl.push_back(mkv("and",      OP_AND,  7'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200));
    tbl.push_back(mkv("nor",      OP_NOR,  7'h0, 32'hF0F0_0000, 32'h0F00_FFFF, 32'h000F_0000));
    tbl.push_back(mkv("or",       OP_OR,   7'h0, 32'h1200_0034, 32'h0034_5600, 32'h1234_5634));
    tbl.push_back(mkv("xor",      OP_XOR,  7'h0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F));
    tbl.push_back(mkv("sll",      OP_SLL,  7'h0, 32'd1,        32'hFFFF_FFE4, 32'h0000_0010));
    tbl.push_back(mkv("srl",      OP_SRL,  7'h0, 32'h8000_0000, 32'h0000_001F, 32'd1));
    tbl.push_back(mkv("sra",      OP_SRA,  7'h0, 32'h8000_0000, 32'd4,        32'hF800_0000));
    tbl.push_back(mkv("lui",      OP_LUI,  7'h0, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000));
    tbl.push_back(mkv("mul_w",    12'h0, MD_MUL_W,   32'hFFFF_FFFF, 32'd3,  32'hFFFF_FFFD));
    tbl.push_back(mkv("mulh_w",   12'h0, MD_MULH_W,  32'h8000_0000, 32'd2,  32'hFFFF_FFFF));
    tbl.push_back(mkv("mulh_wu",  12'h0, MD_MULH_WU, 32'h8000_0000, 32'd2,  32'h0000_0001));
    tbl.push_back(mkv("div_w",    12'h0, MD_DIV_W,   32'd7, 32'hFFFF_FFFE,  32'hFFFF_FFFD));
    tbl.push_back(mkv("mod_w",    12'h0, MD_MOD_W,   32'd7, 32'hFFFF_FFFE,  32'd1));
    tbl.push_back(mkv("div_w neg",12'h0, MD_DIV_W,   32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD));
    tbl.push_back(mkv("mod_w neg",12'h0, MD_MOD_W,   32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF));
    tbl.push_back(mkv("div_wu /0",12'h0, MD_DIV_WU,  32'd5, 32'd0,          32'hFFFF_FFFF));
    tbl.push_back(mkv("mod_wu /0",12'h0, MD_MOD_WU,  32'd5, 32'd0,          32'd5));
    tbl.push_back(mkv("div_w ovf",12'h0, MD_DIV_W,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
    tbl.push_back(mkv("mod_w ovf",12'h0, MD_MOD_W,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0));

    alu_tab = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR,
                OP_SLL, OP_SRL, OP_SRA, OP_LUI};
    md_tab  = '{MD_MUL_W, MD_MULH_W, MD_MULH_WU, MD_DIV_W, MD_MOD_W, MD_DIV_WU, MD_MOD_WU};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst to_mem_valid", {31'd0, exe_to_mem_valid}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst allowin",      {31'd0, exe_allowin}, 32'd1);
    check("rst to_mem_valid", {31'd0, exe_to_mem_valid}, 32'd0);
    check("rst sram_en",      {31'd0, data_sram_en}, 32'd0);
    check("rst sram_we",      {28'd0, data_sram_we}, 32'd0);
    check("rst fw_dest",      {27'd0, exe_fw_dest}, 32'd0);
    check("rst fw_block",     {31'd0, exe_fw_block}, 32'd0);

    foreach (tbl[i]) begin
      check({tbl[i].name, " model"}, ref_res(tbl[i].alu, tbl[i].md, tbl[i].a, tbl[i].b), tbl[i].exp);
      run_instr(tbl[i].name, tbl[i].alu, tbl[i].md, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
    end

    // Store held by MEM back-pressure for three cycles
    mem_allowin = 1'b0;
    set_payload(OP_ADD, 7'h0, 32'h0000_1000, 32'h0000_0024, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1,
                4'hF, 4'h0, 5'd0);
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1 id_to_exe_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("st we",          {28'd0, data_sram_we}, 32'h0000_000F);
      check("st addr",        data_sram_addr, 32'h0000_1024);
      check("st wdata",       data_sram_wdata, 32'hDEAD_BEEF);
      check("st allowin",     {31'd0, exe_allowin}, 32'd0);
      check("st to_mem",      {31'd0, exe_to_mem_valid}, 32'd1);
    end
    mem_allowin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("st left",          {31'd0, exe_to_mem_valid}, 32'd0);
    check("st sram_en off",   {31'd0, data_sram_en}, 32'd0);

    // Load: result not forwardable from EXE
    mem_allowin = 1'b0;
    set_payload(OP_ADD, 7'h0, 32'h0000_2000, 32'd8, 32'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h2, 5'd9);
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1 id_to_exe_valid = 1'b0;
    @(negedge clk);
    check("ld fw_block",      {31'd0, exe_fw_block}, 32'd1);
    check("ld fw_dest",       {27'd0, exe_fw_dest}, 32'd9);
    check("ld sram_en",       {31'd0, data_sram_en}, 32'd1);
    check("ld sram_we",       {28'd0, data_sram_we}, 32'd0);
    check("ld addr",          data_sram_addr, 32'h0000_2008);
    check("ld load_op",       {28'd0, exe_load_op}, 32'd2);
    mem_allowin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ld fw_dest after", {27'd0, exe_fw_dest}, 32'd0);

    // Reset in the middle of a division, then a clean division
    set_payload(12'h0, MD_DIV_W, 32'd1000, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd3);
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1 id_to_exe_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("mid-div busy block", {31'd0, exe_fw_block}, 32'd1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort to_mem",     {31'd0, exe_to_mem_valid}, 32'd0);
    check("abort allowin",    {31'd0, exe_allowin}, 32'd1);
    check("abort fw_block",   {31'd0, exe_fw_block}, 32'd0);
    check("abort fw_dest",    {27'd0, exe_fw_dest}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    run_instr("div after rst", 12'h0, MD_DIV_W, 32'd100, 32'd7, 32'd14, 0);
    run_instr("mod after rst", 12'h0, MD_MOD_W, 32'd100, 32'd7, 32'd2, 0);

    // Randomized instructions with occasional back-pressure
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [11:0] alu;
      logic [6:0]  md;
      logic [31:0] a, b;
      k = $urandom_range(0, 18);
      alu = (k < 12) ? alu_tab[k] : 12'h0;
      md  = (k < 12) ? 7'h0 : md_tab[k - 12];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_instr($sformatf("rand%0d", i), alu, md, a, b, ref_res(alu, md, a, b),
                int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
